// File: rtl/pc_gen_if.sv
// ============================================================================
// Module   : pc_gen_if
// Purpose  : Fetch/redirect bundle between the pipeline and the PC generator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_gen_if #(
    parameter int XLEN = 64
);
    logic            stall_i;
    logic            fetch_valid_o;
    logic            fetch_ready_i;
    logic            inst_len2_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_tgt_i;
    logic            trap_taken_i;
    logic [XLEN-1:0] trap_tgt_i;
    logic            xret_i;
    logic [XLEN-1:0] xret_tgt_i;
    logic            wfi_i;
    logic            irq_pending_i;
    logic [XLEN-1:0] pc_o;
    logic [1:0]      state_o;
    logic            exc_en_o;
    logic [3:0]      exc_code_o;
    logic [XLEN-1:0] exc_val_o;

    modport slave (
        input  stall_i, fetch_ready_i, inst_len2_i,
        input  branch_taken_i, branch_tgt_i, trap_taken_i, trap_tgt_i,
        input  xret_i, xret_tgt_i, wfi_i, irq_pending_i,
        output fetch_valid_o, pc_o, state_o, exc_en_o, exc_code_o, exc_val_o
    );

    modport master (
        output stall_i, fetch_ready_i, inst_len2_i,
        output branch_taken_i, branch_tgt_i, trap_taken_i, trap_tgt_i,
        output xret_i, xret_tgt_i, wfi_i, irq_pending_i,
        input  fetch_valid_o, pc_o, state_o, exc_en_o, exc_code_o, exc_val_o
    );
endinterface

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
// Module   : pc_gen
// Purpose  : Program-counter generator with redirect priority, WFI sleep and
//            sticky misaligned-PC exception.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_gen #(
    parameter int          XLEN       = 64,
    parameter logic [63:0] RESET_VEC  = 64'h8000_0000,
    parameter bit          C_EXT      = 1'b0,
    parameter int          BOOT_DELAY = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    pc_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WFI  = 2'd2,
        ST_EXC  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] c_reset_pc = RESET_VEC[XLEN-1:0];
    localparam int              c_cnt_w    = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BOOT_DELAY - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     w_pc_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [XLEN-1:0]     w_step;
    logic [XLEN-1:0]     w_pc_seq;
    logic                w_load;
    logic [XLEN-1:0]     w_load_tgt;

    function automatic logic misaligned(input logic [XLEN-1:0] pc);
        return C_EXT ? pc[0] : |pc[1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= c_reset_pc;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_load_tgt  = bus.trap_tgt_i;
        w_step      = (C_EXT && bus.inst_len2_i) ? XLEN'(2) : XLEN'(4);
        w_pc_seq    = r_pc + w_step;

        unique case (r_state)
            ST_BOOT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Trap entry overrides stall; everything else waits for it.
                if (bus.trap_taken_i) begin
                    w_load = 1'b1;
                end else if (!bus.stall_i) begin
                    if (bus.xret_i) begin
                        w_load     = 1'b1;
                        w_load_tgt = bus.xret_tgt_i;
                    end else if (bus.branch_taken_i) begin
                        w_load     = 1'b1;
                        w_load_tgt = bus.branch_tgt_i;
                    end else if (bus.fetch_ready_i) begin
                        w_pc_nxt = w_pc_seq;
                        if (bus.wfi_i) begin
                            w_state_nxt = ST_WFI;
                        end
                    end
                end
            end
            ST_WFI: begin
                if (bus.trap_taken_i) begin
                    w_load = 1'b1;
                end else if (bus.irq_pending_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_EXC: begin
                w_load = bus.trap_taken_i;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        // Every redirect funnels here so the alignment check covers them all.
        if (w_load) begin
            w_pc_nxt    = w_load_tgt;
            w_state_nxt = misaligned(w_load_tgt) ? ST_EXC : ST_RUN;
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.state_o       = r_state;
    assign bus.fetch_valid_o = (r_state == ST_RUN);
    assign bus.exc_en_o      = (r_state == ST_EXC);
    assign bus.exc_code_o    = 4'd0;
    assign bus.exc_val_o     = (r_state == ST_EXC) ? r_pc : '0;

endmodule

`default_nettype wire
